qsfp_sb_multi_scan: RTL and testbench
=====================================

Name: qsfp_sb_multi_scan

Overview:
- Multi-cage successor to the single-cage QSFP sideband scanner. It services NUM_PORTS cages in one sweep per start.
- For each cage it selects the I2C mux path, then either initialises the sideband I/O expander or reads it to track module insertion and removal.
- It drives the existing I2C command engine through the same IO_CONTROL/IO_ADDR/IO_WDATA/IO_RDATA interface.
- New over the single-cage block: per-port plug tracking, insertion/removal event pulses, INTL status, a transaction timeout with per-port error flags, and a parametrised settle delay.

Parameters:
- NUM_PORTS, 2, number of cages serviced per sweep; legal range 1..4.
- MUX0_VALUES, 32'h00000201, packed 8 bits per port; byte p is the value for mux 0xE0 on port p.
- MUX1_VALUES, 32'h00000000, packed 8 bits per port; byte p is the value for mux 0xE4 on port p.
- DELAY_CYCLES, 16'h0400, idle cycles after each completed transaction; must be >= 1.
- TIMEOUT_CYCLES, 20'hFFFFF, maximum cycles spent waiting for IO_CONTROL_CMPLT.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begins a sweep; sampled only in IDLE.
- init  in  1  captured with start; 1 = initialise expanders, 0 = scan.
- complete  out  1  one-cycle pulse when a sweep ends.
- busy  out  1  high from the cycle after an accepted start until complete.
- plug_present  out  NUM_PORTS  1 = module inserted.
- plug_event  out  NUM_PORTS  one-cycle pulse when bit p of plug_present changes.
- int_active  out  NUM_PORTS  inverted INTL (read bit 1) from the last successful read of port p.
- err  out  NUM_PORTS  sticky timeout flag per port; bit p clears when port p next completes a full command sequence.
- dbg_cstate  out  4  current state encoding.
- dbg_port  out  2  port index currently being serviced.
- IO_CONTROL_PULSE  out  1  one-cycle command strobe.
- IO_CONTROL_RW  out  1  1 = read, 0 = write.
- IO_CONTROL_ID  out  8  device ID.
- IO_ADDR_ADDR  out  8  register address.
- IO_WDATA_WDATA  out  8  write data.
- IO_RDATA_RDATA  in  8  read data; valid while IO_CONTROL_CMPLT is high.
- IO_CONTROL_CMPLT  in  1  command-done pulse.

Behaviour:
- Reset: all outputs 0; plug_present = 0 (all removed); state IDLE; port index 0.
- Command list per port p:
  - C0: write ID E0, addr = mux0[p], data = mux0[p].
  - C1: write ID E4, addr = mux1[p], data = mux1[p].
  - init=1: C2 write ID 40, addr 01, data 00; C3 write ID 40, addr 03, data 06; then the port is done.
  - init=0: C4 read ID 40, addr 00.
- States: IDLE, ISSUE, WAIT, DELAY, DECIDE, NEXT, DONE.
- IDLE -> ISSUE on start. init is captured in the same cycle and the port index is set to 0. start while not IDLE is ignored.
- ISSUE (1 cycle): IO_CONTROL_PULSE = 1 with RW/ID/ADDR/WDATA registered together in that cycle. The fields hold their values until the next ISSUE. The transition to WAIT clears the timeout counter.
- WAIT:
  - CMPLT -> DELAY. For C4, IO_RDATA_RDATA is latched on the CMPLT cycle.
  - Timeout counter reaching TIMEOUT_CYCLES without CMPLT -> set err[p], abandon the remaining commands for that port, go to NEXT. plug state is unchanged.
  - CMPLT arriving in the same cycle as the timeout: CMPLT wins.
- DELAY: waits exactly DELAY_CYCLES cycles, then:
  - to ISSUE of the next command of the port, or
  - to DECIDE after C4, or
  - to NEXT after C3.
- DECIDE (1 cycle). Let r = latched read byte.
  - int_active[p] <= ~r[1].
  - If r[2] = 0 and plug_present[p] = 0: issue C6 (write ID 40, addr 01, data 10), set plug_present[p] = 1, pulse plug_event[p].
  - If r[2] = 1 and plug_present[p] = 1: issue C5 (write ID 40, addr 01, data 00), set plug_present[p] = 0, pulse plug_event[p].
  - Otherwise go to NEXT.
  - plug_present and plug_event update in the DECIDE cycle, before C5/C6 complete.
  - A timeout on C5/C6 sets err[p] but does not revert plug_present.
- NEXT: a port with no timeout clears err[p]. If p == NUM_PORTS-1 -> DONE; else p+1 -> ISSUE.
- DONE (1 cycle): complete = 1, busy drops in the same cycle, -> IDLE. start is accepted again from the following cycle.
- rst asserted mid-sweep: abort immediately, no further strobes, all state returns to reset values.
- Minimum per-command latency: ISSUE 1 cycle + WAIT >= 1 cycle + DELAY_CYCLES.

Test Plan:
- NUM_PORTS=2, start with init=1, CMPLT returned 3 cycles after each strobe -> 8 strobes in order (E0/01/01, E4/00/00, 40/01/00, 40/03/06, then the same four for port 1 with its mux bytes); one complete pulse; plug_present stays 00.
- Scan (init=0), port 0 reads 0x00, port 1 reads 0x04, from reset -> port 0 gets an extra write 40/01/10; plug_present = 01; plug_event pulses 01 once; int_active[0] = 1; port 1 gets no extra write.
- Repeat the scan with port 0 now reading 0x06 -> write 40/01/00 issued; plug_present = 00; plug_event[0] pulses; int_active[0] = 0.
- Port 0 never returns CMPLT with TIMEOUT_CYCLES = 100 -> err = 01 after 100 WAIT cycles; port 1 is still serviced; complete pulses. The next sweep with CMPLT returned normally -> err = 00.
- Assert rst during the DELAY of port 1 -> all outputs 0 the next cycle; no strobe until a new start.
- Assert start while busy, and CMPLT in the same cycle as the timeout -> the extra start is ignored; the command is treated as complete and err is not set.

Source files
------------

// File: rtl/qsfp_sb_multi_scan.sv
// rtl/qsfp_sb_multi_scan.sv - multi-cage QSFP sideband scanner driving the I2C command engine
// Per sweep: mux select, then expander init or read, plug tracking and per-port timeout flags.
module qsfp_sb_multi_scan #(
  parameter int unsigned NUM_PORTS      = 2,
  parameter logic [31:0] MUX0_VALUES    = 32'h00000201,
  parameter logic [31:0] MUX1_VALUES    = 32'h00000000,
  parameter logic [15:0] DELAY_CYCLES   = 16'h0400,
  parameter logic [19:0] TIMEOUT_CYCLES = 20'hFFFFF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 init,
  output logic                 complete,
  output logic                 busy,
  output logic [NUM_PORTS-1:0] plug_present,
  output logic [NUM_PORTS-1:0] plug_event,
  output logic [NUM_PORTS-1:0] int_active,
  output logic [NUM_PORTS-1:0] err,
  output logic [3:0]           dbg_cstate,
  output logic [1:0]           dbg_port,
  output logic                 IO_CONTROL_PULSE,
  output logic                 IO_CONTROL_RW,
  output logic [7:0]           IO_CONTROL_ID,
  output logic [7:0]           IO_ADDR_ADDR,
  output logic [7:0]           IO_WDATA_WDATA,
  input  logic [7:0]           IO_RDATA_RDATA,
  input  logic                 IO_CONTROL_CMPLT
);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_ISSUE  = 4'd1,
    S_WAIT   = 4'd2,
    S_DELAY  = 4'd3,
    S_DECIDE = 4'd4,
    S_NEXT   = 4'd5,
    S_DONE   = 4'd6
  } state_t;

  localparam logic [2:0] C_MUX0   = 3'd0;
  localparam logic [2:0] C_MUX1   = 3'd1;
  localparam logic [2:0] C_CFG0   = 3'd2;
  localparam logic [2:0] C_CFG1   = 3'd3;
  localparam logic [2:0] C_READ   = 3'd4;
  localparam logic [2:0] C_REMOVE = 3'd5;
  localparam logic [2:0] C_INSERT = 3'd6;
  localparam logic [1:0] LAST_PORT = 2'(NUM_PORTS - 1);

  state_t               state_q, state_d;
  logic [1:0]           port_q, port_d;
  logic [2:0]           cmd_q, cmd_d;
  logic                 init_q, init_d;
  logic [19:0]          tcnt_q, tcnt_d;
  logic [15:0]          dcnt_q, dcnt_d;
  logic [1:0]           rd_bits_q, rd_bits_d;
  logic                 tmo_q, tmo_d;
  logic [NUM_PORTS-1:0] plug_q, plug_d;
  logic [NUM_PORTS-1:0] event_q, event_d;
  logic [NUM_PORTS-1:0] int_q, int_d;
  logic [NUM_PORTS-1:0] err_q, err_d;
  logic                 rw_q, rw_d;
  logic [7:0]           id_q, id_d;
  logic [7:0]           addr_q, addr_d;
  logic [7:0]           wdata_q, wdata_d;

  logic [NUM_PORTS-1:0] port_sel;
  logic                 cur_plug;
  logic [7:0]           mux0_byte;
  logic [7:0]           mux1_byte;
  logic                 unused_rdata;

  // Only INTL (bit 1) and the presence bit (bit 2) matter to this block.
  assign unused_rdata = ^{IO_RDATA_RDATA[7:3], IO_RDATA_RDATA[0]};

  always_comb begin
    port_sel = '0;
    for (int p = 0; p < int'(NUM_PORTS); p++) begin
      port_sel[p] = (port_q == 2'(p));
    end
    cur_plug = |(plug_q & port_sel);
  end

  always_comb begin
    state_d   = state_q;
    port_d    = port_q;
    cmd_d     = cmd_q;
    init_d    = init_q;
    tcnt_d    = tcnt_q;
    dcnt_d    = dcnt_q;
    rd_bits_d = rd_bits_q;
    tmo_d     = tmo_q;
    plug_d    = plug_q;
    event_d   = '0;
    int_d     = int_q;
    err_d     = err_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          init_d  = init;
          port_d  = 2'd0;
          cmd_d   = C_MUX0;
          tmo_d   = 1'b0;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        tcnt_d  = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // Completion is checked first so a CMPLT on the last allowed cycle still counts.
        if (IO_CONTROL_CMPLT) begin
          if (cmd_q == C_READ) rd_bits_d = IO_RDATA_RDATA[2:1];
          dcnt_d  = '0;
          state_d = S_DELAY;
        end else if (tcnt_q == TIMEOUT_CYCLES - 20'd1) begin
          err_d   = err_q | port_sel;
          tmo_d   = 1'b1;
          state_d = S_NEXT;
        end else begin
          tcnt_d = tcnt_q + 20'd1;
        end
      end
      S_DELAY: begin
        if (dcnt_q == DELAY_CYCLES - 16'd1) begin
          case (cmd_q)
            C_MUX0:  begin cmd_d = C_MUX1; state_d = S_ISSUE; end
            C_MUX1:  begin cmd_d = init_q ? C_CFG0 : C_READ; state_d = S_ISSUE; end
            C_CFG0:  begin cmd_d = C_CFG1; state_d = S_ISSUE; end
            C_READ:  state_d = S_DECIDE;
            default: state_d = S_NEXT;
          endcase
        end else begin
          dcnt_d = dcnt_q + 16'd1;
        end
      end
      S_DECIDE: begin
        int_d = rd_bits_q[0] ? (int_q & ~port_sel) : (int_q | port_sel);
        if (!rd_bits_q[1] && !cur_plug) begin
          cmd_d   = C_INSERT;
          plug_d  = plug_q | port_sel;
          event_d = port_sel;
          state_d = S_ISSUE;
        end else if (rd_bits_q[1] && cur_plug) begin
          cmd_d   = C_REMOVE;
          plug_d  = plug_q & ~port_sel;
          event_d = port_sel;
          state_d = S_ISSUE;
        end else begin
          state_d = S_NEXT;
        end
      end
      S_NEXT: begin
        if (!tmo_q) err_d = err_q & ~port_sel;
        tmo_d = 1'b0;
        if (port_q == LAST_PORT) begin
          state_d = S_DONE;
        end else begin
          port_d  = port_q + 2'd1;
          cmd_d   = C_MUX0;
          state_d = S_ISSUE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Command fields are loaded on entry to ISSUE and held until the next command.
  always_comb begin
    mux0_byte = MUX0_VALUES[{port_d, 3'b000} +: 8];
    mux1_byte = MUX1_VALUES[{port_d, 3'b000} +: 8];
    rw_d      = rw_q;
    id_d      = id_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    if (state_d == S_ISSUE) begin
      rw_d    = 1'b0;
      id_d    = 8'h40;
      addr_d  = 8'h01;
      wdata_d = 8'h00;
      case (cmd_d)
        C_MUX0:   begin id_d = 8'hE0; addr_d = mux0_byte; wdata_d = mux0_byte; end
        C_MUX1:   begin id_d = 8'hE4; addr_d = mux1_byte; wdata_d = mux1_byte; end
        C_CFG1:   begin addr_d = 8'h03; wdata_d = 8'h06; end
        C_READ:   begin rw_d = 1'b1; addr_d = 8'h00; end
        C_INSERT: wdata_d = 8'h10;
        default:  ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      port_q    <= '0;
      cmd_q     <= '0;
      init_q    <= 1'b0;
      tcnt_q    <= '0;
      dcnt_q    <= '0;
      rd_bits_q <= '0;
      tmo_q     <= 1'b0;
      plug_q    <= '0;
      event_q   <= '0;
      int_q     <= '0;
      err_q     <= '0;
      rw_q      <= 1'b0;
      id_q      <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      port_q    <= port_d;
      cmd_q     <= cmd_d;
      init_q    <= init_d;
      tcnt_q    <= tcnt_d;
      dcnt_q    <= dcnt_d;
      rd_bits_q <= rd_bits_d;
      tmo_q     <= tmo_d;
      plug_q    <= plug_d;
      event_q   <= event_d;
      int_q     <= int_d;
      err_q     <= err_d;
      rw_q      <= rw_d;
      id_q      <= id_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
    end
  end

  assign complete         = (state_q == S_DONE);
  assign busy             = (state_q != S_IDLE) && (state_q != S_DONE);
  assign plug_present     = plug_q;
  assign plug_event       = event_q;
  assign int_active       = int_q;
  assign err              = err_q;
  assign dbg_cstate       = state_q;
  assign dbg_port         = port_q;
  assign IO_CONTROL_PULSE = (state_q == S_ISSUE);
  assign IO_CONTROL_RW    = rw_q;
  assign IO_CONTROL_ID    = id_q;
  assign IO_ADDR_ADDR     = addr_q;
  assign IO_WDATA_WDATA   = wdata_q;

endmodule

// File: tb/tb_qsfp_sb_multi_scan.sv
// tb/tb_qsfp_sb_multi_scan.sv - randomized bench for qsfp_sb_multi_scan against a sweep-level model
module tb_qsfp_sb_multi_scan;

  localparam int          NP  = 2;
  localparam logic [31:0] M0  = 32'h00000201;
  localparam logic [31:0] M1  = 32'h00000800;
  localparam int          DLY = 4;
  localparam int          TMO = 100;

  logic          clk = 1'b0;
  logic          rst, start, init;
  logic          complete, busy;
  logic [NP-1:0] plug_present, plug_event, int_active, err;
  logic [3:0]    dbg_cstate;
  logic [1:0]    dbg_port;
  logic          pulse, rw;
  logic [7:0]    id, addr, wdata, rdata;
  logic          cmplt;

  always #5 clk = ~clk;

  qsfp_sb_multi_scan #(
    .NUM_PORTS(NP), .MUX0_VALUES(M0), .MUX1_VALUES(M1),
    .DELAY_CYCLES(16'(DLY)), .TIMEOUT_CYCLES(20'(TMO))
  ) dut (
    .clk(clk), .rst(rst), .start(start), .init(init),
    .complete(complete), .busy(busy),
    .plug_present(plug_present), .plug_event(plug_event),
    .int_active(int_active), .err(err),
    .dbg_cstate(dbg_cstate), .dbg_port(dbg_port),
    .IO_CONTROL_PULSE(pulse), .IO_CONTROL_RW(rw), .IO_CONTROL_ID(id),
    .IO_ADDR_ADDR(addr), .IO_WDATA_WDATA(wdata),
    .IO_RDATA_RDATA(rdata), .IO_CONTROL_CMPLT(cmplt)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Stimulus knobs and observation logs
  int          resp_lat = 3;
  logic [NP-1:0] drop = '0;
  logic [7:0]  rd_val [NP];
  int          e0_cnt = 0;
  logic [24:0] log_q [$];
  longint      stamp_q [$];
  longint      cyc = 0;
  int          cmp_cnt = 0;
  int          ev_cnt [NP];

  // Sweep-level reference state
  logic [24:0]   exp_q [$];
  logic [NP-1:0] m_plug = '0, m_int = '0, m_err = '0;
  int            exp_ev [NP];

  always @(posedge clk) cyc <= cyc + 1;

  // I2C engine stand-in: answers each strobe resp_lat cycles later unless told to stay silent
  initial begin : responder
    int cp;
    cp = 0;
    cmplt = 1'b0;
    rdata = 8'h00;
    forever begin
      @(negedge clk);
      if (pulse === 1'b1) begin
        log_q.push_back({rw, id, addr, wdata});
        stamp_q.push_back(cyc);
        if (id == 8'hE0) begin
          cp = (e0_cnt < NP) ? e0_cnt : NP - 1;
          e0_cnt++;
        end
        if (!(id == 8'hE0 && drop[cp])) begin
          repeat (resp_lat) @(posedge clk);
          #1;
          cmplt = 1'b1;
          rdata = rw ? rd_val[cp] : 8'($urandom);
          @(posedge clk);
          #1;
          cmplt = 1'b0;
          rdata = 8'($urandom);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (complete === 1'b1) begin
      cmp_cnt++;
      check("busy_low_at_complete", 64'(busy), 64'd0);
    end
    for (int p = 0; p < NP; p++)
      if (plug_event[p] === 1'b1) ev_cnt[p]++;
  end

  function automatic logic [24:0] wr(input logic [7:0] i, input logic [7:0] a, input logic [7:0] d);
    return {1'b0, i, a, d};
  endfunction

  task automatic model_sweep(input logic i_init);
    exp_q.delete();
    for (int p = 0; p < NP; p++) begin
      logic [7:0] m0, m1, r;
      m0 = 8'(M0 >> (8 * p));
      m1 = 8'(M1 >> (8 * p));
      exp_ev[p] = 0;
      exp_q.push_back(wr(8'hE0, m0, m0));
      if (drop[p]) begin
        m_err[p] = 1'b1;
        continue;
      end
      exp_q.push_back(wr(8'hE4, m1, m1));
      if (i_init) begin
        exp_q.push_back(wr(8'h40, 8'h01, 8'h00));
        exp_q.push_back(wr(8'h40, 8'h03, 8'h06));
      end else begin
        r = rd_val[p];
        exp_q.push_back({1'b1, 8'h40, 8'h00, 8'h00});
        m_int[p] = ~r[1];
        if (!r[2] && !m_plug[p]) begin
          exp_q.push_back(wr(8'h40, 8'h01, 8'h10));
          m_plug[p] = 1'b1;
          exp_ev[p] = 1;
        end else if (r[2] && m_plug[p]) begin
          exp_q.push_back(wr(8'h40, 8'h01, 8'h00));
          m_plug[p] = 1'b0;
          exp_ev[p] = 1;
        end
      end
      m_err[p] = 1'b0;
    end
  endtask

  task automatic run_sweep(input string nm, input logic i_init, input int lat, input bit extra);
    int n;
    int nlog;
    resp_lat = lat;
    e0_cnt   = 0;
    cmp_cnt  = 0;
    log_q.delete();
    stamp_q.delete();
    for (int p = 0; p < NP; p++) ev_cnt[p] = 0;
    @(posedge clk); #1;
    start = 1'b1;
    init  = i_init;
    @(posedge clk); #1;
    start = 1'b0;
    init  = 1'b0;
    check({nm, "_busy_after_start"}, 64'(busy), 64'd1);
    if (drop[0]) begin
      check({nm, "_first_strobe"}, 64'(pulse), 64'd1);
      @(negedge clk);
      n = 0;
      while (err[0] !== 1'b1 && n < 300) begin
        @(negedge clk);
        n++;
      end
      check({nm, "_timeout_latency"}, 64'(n), 64'(TMO + 1));
    end
    if (extra) begin
      repeat (10) @(posedge clk);
      #1;
      start = 1'b1;
      init  = ~i_init;
      @(posedge clk); #1;
      start = 1'b0;
      init  = 1'b0;
    end
    n = 0;
    while (cmp_cnt == 0 && n < 20000) begin
      @(posedge clk);
      n++;
    end
    check({nm, "_complete_seen"}, 64'(cmp_cnt != 0), 64'd1);
    nlog = log_q.size();
    repeat (20) @(posedge clk);
    #1;
    check({nm, "_idle_after"}, 64'(busy), 64'd0);
    check({nm, "_complete_once"}, 64'(cmp_cnt), 64'd1);
    check({nm, "_no_late_strobe"}, 64'(log_q.size()), 64'(nlog));
    model_sweep(i_init);
    check({nm, "_strobe_count"}, 64'(log_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
      logic [24:0] g, e;
      g = log_q[i];
      e = exp_q[i];
      if (e[24]) begin
        g[7:0] = 8'h00;
        e[7:0] = 8'h00;
      end
      check($sformatf("%s_cmd%0d", nm, i), 64'(g), 64'(e));
    end
    if (!drop[0] && stamp_q.size() >= 2)
      check({nm, "_cmd_spacing"}, 64'(stamp_q[1] - stamp_q[0]), 64'(lat + 1 + DLY));
    check({nm, "_plug_present"}, 64'(plug_present), 64'(m_plug));
    check({nm, "_int_active"}, 64'(int_active), 64'(m_int));
    check({nm, "_err"}, 64'(err), 64'(m_err));
    for (int p = 0; p < NP; p++)
      check($sformatf("%s_events_p%0d", nm, p), 64'(ev_cnt[p]), 64'(exp_ev[p]));
  endtask

  initial begin : watchdog
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int n, k, nlog;
    rst   = 1'b1;
    start = 1'b0;
    init  = 1'b0;
    for (int p = 0; p < NP; p++) rd_val[p] = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset_outputs", 64'({complete, busy, plug_present, plug_event, int_active, err,
                               dbg_cstate, dbg_port, pulse, rw, id, addr, wdata}), 64'd0);

    run_sweep("init", 1'b1, 3, 1'b0);

    rd_val[0] = 8'h00;
    rd_val[1] = 8'h04;
    run_sweep("scan_insert", 1'b0, 3, 1'b0);

    rd_val[0] = 8'h06;
    run_sweep("scan_remove", 1'b0, 2, 1'b0);

    drop = 2'b01;
    run_sweep("timeout", 1'b0, 3, 1'b0);
    drop = 2'b00;
    run_sweep("timeout_clear", 1'b0, 3, 1'b0);

    rd_val[0] = 8'($urandom);
    rd_val[1] = 8'($urandom);
    run_sweep("race_busy_start", 1'b0, TMO, 1'b1);

    for (int i = 0; i < 6; i++) begin
      for (int p = 0; p < NP; p++) rd_val[p] = 8'($urandom);
      run_sweep($sformatf("rand%0d", i), 1'($urandom_range(0, 4) == 0), int'($urandom_range(1, 6)), 1'b0);
    end

    // Reset during port 1 DELAY after its mux1 write
    resp_lat = 3;
    e0_cnt   = 0;
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    k = 0;
    while (k < 2 && n < 2000) begin
      @(negedge clk);
      n++;
      if (pulse === 1'b1 && id == 8'hE4) k++;
    end
    check("rst_reached_port1", 64'(k), 64'd2);
    repeat (5) @(posedge clk);
    #1;
    check("rst_busy_before", 64'(busy), 64'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst_outputs", 64'({complete, busy, plug_present, plug_event, int_active, err,
                             dbg_cstate, dbg_port, pulse, rw, id, addr, wdata}), 64'd0);
    m_plug = '0;
    m_int  = '0;
    m_err  = '0;
    nlog = log_q.size();
    repeat (30) @(posedge clk);
    #1;
    check("rst_no_strobe", 64'(log_q.size()), 64'(nlog));

    rd_val[0] = 8'h02;
    rd_val[1] = 8'h00;
    run_sweep("post_rst", 1'b0, 3, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
